// File: rtl/renode_request_arbiter.sv
// rtl/renode_request_arbiter.sv - round-robin request arbiter with one outstanding transaction
module renode_request_arbiter #(
  parameter int RequestersCount = 4,
  parameter int AddressWidth    = 32,
  parameter int DataWidth       = 64,
  parameter int TimeoutCycles   = 1024,
  localparam int IdWidth        = (RequestersCount > 1) ? $clog2(RequestersCount) : 1,
  localparam int CntWidth       = $clog2(TimeoutCycles)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [RequestersCount-1:0]            req_valid,
  input  logic [RequestersCount-1:0]            req_write,
  input  logic [2*RequestersCount-1:0]          req_size,
  input  logic [AddressWidth*RequestersCount-1:0] req_addr,
  input  logic [DataWidth*RequestersCount-1:0]  req_wdata,
  output logic [RequestersCount-1:0]            req_ready,
  output logic [RequestersCount-1:0]            rsp_valid,
  output logic [DataWidth-1:0]                  rsp_rdata,
  output logic                                  rsp_error,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic                                  out_write,
  output logic [1:0]                            out_size,
  output logic [AddressWidth-1:0]               out_addr,
  output logic [DataWidth-1:0]                  out_wdata,
  output logic [IdWidth-1:0]                    out_id,
  input  logic                                  in_valid,
  input  logic [DataWidth-1:0]                  in_rdata,
  input  logic                                  in_error,
  input  logic                                  sync_req,
  output logic                                  sync_ack,
  output logic                                  stray_rsp
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_RSP, S_RESPOND, S_SYNC} state_t;

  state_t                  r_state;
  logic [IdWidth-1:0]      r_ptr;
  logic [IdWidth-1:0]      r_id;
  logic [CntWidth-1:0]     r_cnt;
  logic                    r_write;
  logic [1:0]              r_size;
  logic [AddressWidth-1:0] r_addr;
  logic [DataWidth-1:0]    r_wdata;
  logic [DataWidth-1:0]    r_rsp_rdata;
  logic                    r_rsp_error;
  logic                    r_stray;

  logic                    w_any;
  logic                    w_grant_en;
  logic [IdWidth-1:0]      w_grant;
  logic                    w_sel_write;
  logic [1:0]              w_sel_size;
  logic [AddressWidth-1:0] w_sel_addr;
  logic [DataWidth-1:0]    w_sel_wdata;

  // Keep only the 8/16/32/64 LSBs selected by size; everything above is zero.
  function automatic logic [DataWidth-1:0] size_mask(input logic [DataWidth-1:0] data,
                                                     input logic [1:0] size);
    logic [DataWidth-1:0] m;
    int bits;
    m    = '0;
    bits = 8 << size;
    for (int i = 0; i < DataWidth; i++) m[i] = (i < bits);
    return data & m;
  endfunction

  // Round-robin pick: the valid requester closest above ptr (with wrap) wins.
  always_comb begin
    int best_d;
    int d;
    w_any   = 1'b0;
    w_grant = '0;
    best_d  = RequestersCount;
    d       = 0;
    for (int i = 0; i < RequestersCount; i++) begin
      d = i - int'(r_ptr);
      if (d < 0) d = d + RequestersCount;
      if (req_valid[i] && d < best_d) begin
        best_d  = d;
        w_any   = 1'b1;
        w_grant = IdWidth'(i);
      end
    end
  end

  // Mux out the granted requester's fields and build the one-hot accept/response pulses.
  always_comb begin
    w_grant_en  = (r_state == S_IDLE) && !rst && !sync_req && w_any;
    w_sel_write = 1'b0;
    w_sel_size  = '0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    req_ready   = '0;
    rsp_valid   = '0;
    for (int i = 0; i < RequestersCount; i++) begin
      if (w_grant == IdWidth'(i)) begin
        w_sel_write = req_write[i];
        w_sel_size  = req_size[2*i +: 2];
        w_sel_addr  = req_addr[AddressWidth*i +: AddressWidth];
        w_sel_wdata = req_wdata[DataWidth*i +: DataWidth];
      end
      req_ready[i] = w_grant_en && (w_grant == IdWidth'(i));
      rsp_valid[i] = (r_state == S_RESPOND) && (r_id == IdWidth'(i));
    end
  end

  // Transaction FSM: grant, issue downstream, wait (with timeout), respond; sync only from idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_id        <= '0;
      r_cnt       <= '0;
      r_write     <= 1'b0;
      r_size      <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rsp_rdata <= '0;
      r_rsp_error <= 1'b0;
      r_stray     <= 1'b0;
    end else begin
      r_stray <= in_valid && (r_state != S_WAIT_RSP);
      case (r_state)
        S_IDLE: begin
          if (sync_req) begin
            r_state <= S_SYNC;
          end else if (w_any) begin
            r_id    <= w_grant;
            r_write <= w_sel_write;
            r_size  <= w_sel_size;
            r_addr  <= w_sel_addr;
            r_wdata <= w_sel_wdata;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (out_ready) begin
            r_cnt   <= '0;
            r_state <= S_WAIT_RSP;
          end
        end
        S_WAIT_RSP: begin
          if (in_valid) begin
            r_rsp_rdata <= r_write ? '0 : size_mask(in_rdata, r_size);
            r_rsp_error <= in_error;
            r_state     <= S_RESPOND;
          end else if (r_cnt == CntWidth'(TimeoutCycles - 1)) begin
            r_rsp_rdata <= '0;
            r_rsp_error <= 1'b1;
            r_state     <= S_RESPOND;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RESPOND: begin
          if (int'(r_id) == RequestersCount - 1) r_ptr <= '0;
          else r_ptr <= r_id + 1'b1;
          r_state <= S_IDLE;
        end
        S_SYNC: begin
          if (!sync_req) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign out_valid = (r_state == S_ISSUE);
  assign out_write = r_write;
  assign out_size  = r_size;
  assign out_addr  = r_addr;
  assign out_wdata = size_mask(r_wdata, r_size);
  assign out_id    = r_id;
  assign rsp_rdata = (r_state == S_RESPOND) ? r_rsp_rdata : '0;
  assign rsp_error = (r_state == S_RESPOND) && r_rsp_error;
  assign sync_ack  = (r_state == S_SYNC);
  assign stray_rsp = r_stray;

endmodule
